glb_mode_sequencer: RTL and testbench

GLB_MODE_SEQUENCER -- requirements
Module: glb_mode_sequencer

---
 rtl/glb_mode_sequencer_pkg.sv | 15 +
 rtl/glb_mode_sequencer_guard_timer.sv | 22 ++
 rtl/glb_mode_sequencer.sv | 126 ++++++++++++
 tb/tb_glb_mode_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/glb_mode_sequencer_pkg.sv
// glb_mode_sequencer_pkg: shared state encoding and phase codes for the GLB mode sequencer.
package glb_mode_sequencer_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_NOC,
    ST_RUN_LRN,
    ST_RUN_PAD,
    ST_GUARD,
    ST_DONE
  } state_e;
  localparam logic [1:0] PHASE_NONE = 2'd0;
  localparam logic [1:0] PHASE_NOC  = 2'd1;
  localparam logic [1:0] PHASE_LRN  = 2'd2;
  localparam logic [1:0] PHASE_PAD  = 2'd3;
endpackage

// File: rtl/glb_mode_sequencer_guard_timer.sv
// guard_timer: loadable down-counter whose expire flag marks the last idle cycle between GLB owners.
module guard_timer #(
  parameter int GUARD_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   load_i,
  input  logic                   dec_i,
  input  logic [GUARD_WIDTH-1:0] load_val_i,
  output logic                   expired_o
);
  logic [GUARD_WIDTH-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = clr_i                        ? '0 :
            load_i                       ? load_val_i :
            (dec_i && cnt_q != '0)       ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/glb_mode_sequencer.sv
// glb_mode_sequencer: hands GLB ownership NOC -> LRN -> PAD with guard gaps between owners.
// Every output is a flop computed from the next state, so enables drop cleanly on reset or abort.
module glb_mode_sequencer
  import glb_mode_sequencer_pkg::*;
#(
  parameter int GUARD_CYCLES = 2,
  parameter int GUARD_WIDTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       cfg_lrn,
  input  logic       cfg_pad,
  input  logic       noc_done,
  input  logic       lrn_done,
  input  logic       pad_done,
  output logic       noc_enable,
  output logic       lrn_enable,
  output logic       padding_enable,
  output logic       noc_start,
  output logic       lrn_start,
  output logic       pad_start,
  output logic       layer_done,
  output logic       busy,
  output logic [1:0] phase,
  output logic       protocol_err
);
  state_e     state_q, state_d, after_guard;
  logic       lrn_cfg_q, lrn_cfg_d, pad_cfg_q, pad_cfg_d;
  logic       err_q, err_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] en_q, st_q;
  logic       busy_q, done_q;
  logic       start_acc, stray, g_load, g_dec, g_expired;
  guard_timer #(.GUARD_WIDTH(GUARD_WIDTH)) u_guard (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (abort),
    .load_i     (g_load),
    .dec_i      (g_dec),
    .load_val_i (GUARD_WIDTH'(GUARD_CYCLES - 1)),
    .expired_o  (g_expired)
  );
  // The phase register still names the finished owner while in GUARD, which selects the successor.
  always_comb
    after_guard = (phase_q == PHASE_NOC) ? (lrn_cfg_q ? ST_RUN_LRN : pad_cfg_q ? ST_RUN_PAD : ST_DONE) :
                  (phase_q == PHASE_LRN) ? (pad_cfg_q ? ST_RUN_PAD : ST_DONE) : ST_DONE;
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    g_load    = 1'b0;
    g_dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_acc = start;
        state_d   = start ? ST_RUN_NOC : ST_IDLE;
      end
      ST_RUN_NOC: begin
        g_load  = noc_done;
        state_d = noc_done ? ST_GUARD : state_q;
      end
      ST_RUN_LRN: begin
        g_load  = lrn_done;
        state_d = lrn_done ? ST_GUARD : state_q;
      end
      ST_RUN_PAD: begin
        g_load  = pad_done;
        state_d = pad_done ? ST_GUARD : state_q;
      end
      ST_GUARD: begin
        g_dec   = !g_expired;
        state_d = g_expired ? after_guard : state_q;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      start_acc = 1'b0;
      g_load    = 1'b0;
      g_dec     = 1'b0;
    end
  end
  always_comb begin
    stray     = (noc_done && state_q != ST_RUN_NOC) ||
                (lrn_done && state_q != ST_RUN_LRN) ||
                (pad_done && state_q != ST_RUN_PAD);
    err_d     = abort ? err_q : ((start_acc ? 1'b0 : err_q) | stray);
    lrn_cfg_d = start_acc ? cfg_lrn : lrn_cfg_q;
    pad_cfg_d = start_acc ? cfg_pad : pad_cfg_q;
    phase_d   = (state_d == ST_RUN_NOC) ? PHASE_NOC :
                (state_d == ST_RUN_LRN) ? PHASE_LRN :
                (state_d == ST_RUN_PAD) ? PHASE_PAD :
                (state_d == ST_GUARD)   ? phase_q : PHASE_NONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lrn_cfg_q <= 1'b0;
      pad_cfg_q <= 1'b0;
      err_q     <= 1'b0;
      phase_q   <= PHASE_NONE;
      en_q      <= '0;
      st_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lrn_cfg_q <= lrn_cfg_d;
      pad_cfg_q <= pad_cfg_d;
      err_q     <= err_d;
      phase_q   <= phase_d;
      en_q      <= {state_d == ST_RUN_NOC, state_d == ST_RUN_LRN, state_d == ST_RUN_PAD};
      st_q      <= {state_d == ST_RUN_NOC, state_d == ST_RUN_LRN, state_d == ST_RUN_PAD} &
                   ~{state_q == ST_RUN_NOC, state_q == ST_RUN_LRN, state_q == ST_RUN_PAD};
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
    end
  assign {noc_enable, lrn_enable, padding_enable} = en_q;
  assign {noc_start, lrn_start, pad_start}        = st_q;
  assign layer_done   = done_q;
  assign busy         = busy_q;
  assign phase        = phase_q;
  assign protocol_err = err_q;
endmodule

// File: tb/tb_glb_mode_sequencer.sv
// tb_glb_mode_sequencer: directed scenarios with a per-cycle expected-output scoreboard.
module tb_glb_mode_sequencer;
  typedef struct packed {
    logic [2:0] en;
    logic [2:0] st;
    logic       ld;
    logic       busy;
    logic [1:0] ph;
    logic       err;
  } obs_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, cfg_lrn = 1'b0, cfg_pad = 1'b0;
  logic noc_done = 1'b0, lrn_done = 1'b0, pad_done = 1'b0;
  logic noc_enable, lrn_enable, padding_enable, noc_start, lrn_start, pad_start;
  logic layer_done, busy, protocol_err;
  logic [1:0] phase;
  int n_vec = 0, n_err = 0;
  obs_t exp_q[$];
  glb_mode_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_lrn(cfg_lrn), .cfg_pad(cfg_pad),
    .noc_done(noc_done), .lrn_done(lrn_done), .pad_done(pad_done),
    .noc_enable(noc_enable), .lrn_enable(lrn_enable), .padding_enable(padding_enable),
    .noc_start(noc_start), .lrn_start(lrn_start), .pad_start(pad_start),
    .layer_done(layer_done), .busy(busy), .phase(phase), .protocol_err(protocol_err)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] oh(input logic [1:0] p);
    return p == 2'd1 ? 3'b100 : p == 2'd2 ? 3'b010 : p == 2'd3 ? 3'b001 : 3'b000;
  endfunction
  function automatic obs_t o_run(input logic [1:0] p, input logic first, input logic err);
    return '{en: oh(p), st: first ? oh(p) : 3'b000, ld: 1'b0, busy: 1'b1, ph: p, err: err};
  endfunction
  function automatic obs_t o_guard(input logic [1:0] p, input logic err);
    return '{en: 3'b000, st: 3'b000, ld: 1'b0, busy: 1'b1, ph: p, err: err};
  endfunction
  function automatic obs_t o_done(input logic err);
    return '{en: 3'b000, st: 3'b000, ld: 1'b1, busy: 1'b1, ph: 2'd0, err: err};
  endfunction
  function automatic obs_t o_idle(input logic err);
    return '{en: 3'b000, st: 3'b000, ld: 1'b0, busy: 1'b0, ph: 2'd0, err: err};
  endfunction
  task automatic chk(input string tag, input obs_t e);
    obs_t got, want;
    exp_q.push_back(e);
    got = '{en: {noc_enable, lrn_enable, padding_enable}, st: {noc_start, lrn_start, pad_start},
            ld: layer_done, busy: busy, ph: phase, err: protocol_err};
    want = exp_q.pop_front();
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask
  task automatic tick(input string tag, input obs_t e);
    @(posedge clk);
    #1;
    chk(tag, e);
  endtask
  // Caller is observing the first cycle of phase p; runs n more cycles, pulses done, checks both guard cycles.
  task automatic phase_run(input logic [1:0] p, input int n, input logic err);
    for (int i = 0; i < n; i++) tick("run_hold", o_run(p, 1'b0, err));
    {noc_done, lrn_done, pad_done} = oh(p);
    tick("guard1", o_guard(p, err));
    {noc_done, lrn_done, pad_done} = 3'b000;
    tick("guard2", o_guard(p, err));
  endtask
  initial begin
    #1;
    chk("reset_state", o_idle(1'b0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick("idle_after_reset", o_idle(1'b0));
    // Full NOC/LRN/PAD sequence; cfg changes after acceptance must be ignored
    {start, cfg_lrn, cfg_pad} = 3'b111;
    tick("noc_first", o_run(2'd1, 1'b1, 1'b0));
    {start, cfg_lrn, cfg_pad} = 3'b000;
    phase_run(2'd1, 5, 1'b0);
    tick("lrn_first", o_run(2'd2, 1'b1, 1'b0));
    phase_run(2'd2, 5, 1'b0);
    tick("pad_first", o_run(2'd3, 1'b1, 1'b0));
    phase_run(2'd3, 5, 1'b0);
    tick("done_full", o_done(1'b0));
    tick("idle_full", o_idle(1'b0));
    // NOC only, done on first RUN cycle
    start = 1'b1;
    tick("noc_only_first", o_run(2'd1, 1'b1, 1'b0));
    start = 1'b0;
    phase_run(2'd1, 0, 1'b0);
    tick("done_noc_only", o_done(1'b0));
    tick("idle_noc_only", o_idle(1'b0));
    // Foreign done during RUN_NOC
    start = 1'b1;
    tick("err_noc_first", o_run(2'd1, 1'b1, 1'b0));
    start = 1'b0;
    lrn_done = 1'b1;
    tick("err_set", o_run(2'd1, 1'b0, 1'b1));
    lrn_done = 1'b0;
    tick("err_state_kept", o_run(2'd1, 1'b0, 1'b1));
    phase_run(2'd1, 0, 1'b1);
    tick("err_done", o_done(1'b1));
    tick("err_idle_sticky", o_idle(1'b1));
    // Next start clears the error; abort during RUN_LRN
    {start, cfg_lrn, cfg_pad} = 3'b110;
    tick("err_cleared", o_run(2'd1, 1'b1, 1'b0));
    {start, cfg_lrn, cfg_pad} = 3'b000;
    phase_run(2'd1, 0, 1'b0);
    tick("abort_lrn_first", o_run(2'd2, 1'b1, 1'b0));
    tick("abort_lrn_hold", o_run(2'd2, 1'b0, 1'b0));
    abort = 1'b1;
    tick("abort_idle", o_idle(1'b0));
    abort = 1'b0;
    tick("abort_no_done", o_idle(1'b0));
    // Async reset during RUN_PAD
    {start, cfg_lrn, cfg_pad} = 3'b101;
    tick("rst_noc_first", o_run(2'd1, 1'b1, 1'b0));
    {start, cfg_lrn, cfg_pad} = 3'b000;
    phase_run(2'd1, 0, 1'b0);
    tick("rst_pad_first", o_run(2'd3, 1'b1, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("rst_async_drop", o_idle(1'b0));
    @(posedge clk);
    #1;
    chk("rst_held", o_idle(1'b0));
    rst_n = 1'b1;
    tick("rst_released", o_idle(1'b0));
    start = 1'b1;
    tick("rst_restart_noc", o_run(2'd1, 1'b1, 1'b0));
    start = 1'b0;
    phase_run(2'd1, 0, 1'b0);
    tick("rst_restart_done", o_done(1'b0));
    tick("rst_restart_idle", o_idle(1'b0));
    // start held for 10 cycles runs one sequence with no error
    start = 1'b1;
    tick("hold_noc_first", o_run(2'd1, 1'b1, 1'b0));
    for (int i = 0; i < 9; i++) tick("hold_noc", o_run(2'd1, 1'b0, 1'b0));
    start = 1'b0;
    phase_run(2'd1, 0, 1'b0);
    tick("hold_done", o_done(1'b0));
    tick("hold_idle", o_idle(1'b0));
    tick("hold_idle2", o_idle(1'b0));
    // start with abort in IDLE stays idle; done outside RUN flags an error
    start = 1'b1;
    abort = 1'b1;
    tick("start_abort_idle", o_idle(1'b0));
    {start, abort} = 2'b00;
    pad_done = 1'b1;
    tick("idle_stray_done", o_idle(1'b1));
    pad_done = 1'b0;
    tick("idle_stray_sticky", o_idle(1'b1));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
